// File: rtl/l2_acc_pkg.sv
// -----------------------------------------------------------------------------
// l2_acc_pkg
// Shared definitions for the sum-of-squares accumulator scheduler:
//   - default widths and frame/latency parameters
//   - scheduler state encoding
//   - counter width helper and the derived default counter widths
// -----------------------------------------------------------------------------
package l2_acc_pkg;

    localparam int DW_DEF      = 8;   // element width
    localparam int FW_DEF      = 20;  // accumulator / result width
    localparam int LEN_DEF     = 4;   // elements per frame
    localparam int ACC_LAT_DEF = 2;   // accumulator latency in cycles

    // Bits needed to hold any value in 0..max_val (never less than 1).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Element counter spans 0..LEN, drain counter spans 0..ACC_LAT+1.
    localparam int CNT_W = cnt_width(LEN_DEF);
    localparam int DRN_W = cnt_width(ACC_LAT_DEF + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        RESULT
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter, purely combinational. The "last granted"
// pointer is owned by the parent so it only advances when a frame completes.
//
// Ports:
//   req         in  2  request lines
//   last        in  1  index of the requester served most recently
//   grant       out 1  index of the winning requester
//   grant_valid out 1  at least one request is present
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |req;
        // With a single requester it wins outright; with two, the one that
        // was not served last time wins.
        if (&req) begin
            grant = ~last;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/l2_acc_sched.sv
// -----------------------------------------------------------------------------
// l2_acc_sched
// Shares one sum-of-squares accumulator between two requesters. Each frame of
// LEN elements is granted round-robin, then the accumulator is sequenced:
// clear, stream the elements, drain the pipeline, capture the result.
//
// Ports:
//   clk           in  1       rising-edge clock
//   reset         in  1       asynchronous active-low reset
//   req_valid     in  2       per-requester element valid
//   req_data      in  2xDW    per-requester element
//   req_ready     out 2       per-requester element accept
//   acc_clr       out 1       one-cycle accumulator clear
//   acc_a         out DW      element to accumulator (registered)
//   acc_valid_in  out 1       element valid to accumulator (registered)
//   acc_f         in  FW      accumulator running sum
//   acc_overflow  in  1       accumulator overflow indication
//   res_valid     out 1       result valid
//   res_ready     in  1       result accept
//   res_data      out FW      frame sum of squares (saturated on overflow)
//   res_id        out 1       requester that owned the frame
//   res_ovf       out 1       frame overflowed
//   busy          out 1       high in any state except IDLE
// -----------------------------------------------------------------------------
module l2_acc_sched
    import l2_acc_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int FW      = FW_DEF,
    parameter int LEN     = LEN_DEF,
    parameter int ACC_LAT = ACC_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    input  logic [1:0][DW-1:0]   req_data,
    output logic [1:0]           req_ready,
    output logic                 acc_clr,
    output logic [DW-1:0]        acc_a,
    output logic                 acc_valid_in,
    input  logic [FW-1:0]        acc_f,
    input  logic                 acc_overflow,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [FW-1:0]        res_data,
    output logic                 res_id,
    output logic                 res_ovf,
    output logic                 busy
);

    localparam int CW  = cnt_width(LEN);
    localparam int DRW = cnt_width(ACC_LAT + 1);

    state_e          state_q,     state_d;
    logic            grant_q,     grant_d;
    logic            last_q,      last_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [DRW-1:0]  drn_q,       drn_d;
    logic            sticky_q,    sticky_d;
    logic [DW-1:0]   acc_a_q,     acc_a_d;
    logic            acc_vin_q,   acc_vin_d;
    logic            res_valid_q, res_valid_d;
    logic [FW-1:0]   res_data_q,  res_data_d;
    logic            res_id_q,    res_id_d;
    logic            res_ovf_q,   res_ovf_d;

    logic            arb_grant;
    logic            arb_valid;
    logic            ovf_now;

    rr_arb2 u_arb (
        .req         (req_valid),
        .last        (last_q),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    // Overflow seen so far in this frame, including the current cycle.
    assign ovf_now = sticky_q | acc_overflow;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        drn_d       = drn_q;
        sticky_d    = sticky_q;
        acc_a_d     = acc_a_q;
        acc_vin_d   = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_ovf_d   = res_ovf_q;
        req_ready   = '0;
        acc_clr     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    state_d = CLEAR;
                end
            end

            CLEAR: begin
                acc_clr  = 1'b1;
                cnt_d    = '0;
                drn_d    = '0;
                sticky_d = 1'b0;
                state_d  = STREAM;
            end

            STREAM: begin
                req_ready[grant_q] = 1'b1;
                sticky_d           = ovf_now;
                if (req_valid[grant_q]) begin
                    acc_a_d   = req_data[grant_q];
                    acc_vin_d = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                    if (cnt_q == CW'(LEN - 1)) begin
                        drn_d   = '0;
                        state_d = DRAIN;
                    end
                end
            end

            // Covers the issue register plus the accumulator latency; on the
            // final cycle acc_f already includes the last element.
            DRAIN: begin
                sticky_d = ovf_now;
                if (drn_q == DRW'(ACC_LAT)) begin
                    res_valid_d = 1'b1;
                    res_data_d  = ovf_now ? '1 : acc_f;
                    res_ovf_d   = ovf_now;
                    res_id_d    = grant_q;
                    state_d     = RESULT;
                end else begin
                    drn_d = drn_q + DRW'(1);
                end
            end

            RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    last_d      = grant_q;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;  // requester 0 wins the first contested grant
            cnt_q       <= '0;
            drn_q       <= '0;
            sticky_q    <= 1'b0;
            acc_a_q     <= '0;
            acc_vin_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            drn_q       <= drn_d;
            sticky_q    <= sticky_d;
            acc_a_q     <= acc_a_d;
            acc_vin_q   <= acc_vin_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign acc_a        = acc_a_q;
    assign acc_valid_in = acc_vin_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_id       = res_id_q;
    assign res_ovf      = res_ovf_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_l2_acc_sched.sv
// -----------------------------------------------------------------------------
// tb_l2_acc_sched
// Drives two element sources from per-requester queues, pairs the scheduler
// with a behavioural accumulator of latency 2, and compares every frame result
// against the plain sum of squares of the elements that were sent.
// -----------------------------------------------------------------------------
module tb_l2_acc_sched;

    localparam int DW      = 8;
    localparam int FW      = 20;
    localparam int LEN     = 4;
    localparam int ACC_LAT = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [1:0]          req_valid;
    logic [1:0][DW-1:0]  req_data;
    logic [1:0]          req_ready;
    logic                acc_clr;
    logic [DW-1:0]       acc_a;
    logic                acc_valid_in;
    logic [FW-1:0]       acc_f;
    logic                acc_overflow;
    logic                res_valid;
    logic                res_ready;
    logic [FW-1:0]       res_data;
    logic                res_id;
    logic                res_ovf;
    logic                busy;

    l2_acc_sched #(.DW(DW), .FW(FW), .LEN(LEN), .ACC_LAT(ACC_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .acc_clr      (acc_clr),
        .acc_a        (acc_a),
        .acc_valid_in (acc_valid_in),
        .acc_f        (acc_f),
        .acc_overflow (acc_overflow),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_id       (res_id),
        .res_ovf      (res_ovf),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural accumulator, f valid ACC_LAT cycles later --
    bit          ovf_inj;
    bit          p_v;
    bit [DW-1:0] p_a;
    bit [31:0]   m_sum;

    always @(posedge clk) begin
        p_v   <= acc_valid_in & ~acc_clr;
        p_a   <= acc_a;
        m_sum <= acc_clr ? 32'd0 : m_sum + (p_v ? 32'(p_a) * 32'(p_a) : 32'd0);
    end
    assign acc_f        = m_sum[FW-1:0];
    assign acc_overflow = ovf_inj;

    // ---------------- sources and event counters -----------------------------
    logic [DW:0] sq0[$];   // {valid, data}; valid=0 entries are bubble cycles
    logic [DW:0] sq1[$];
    int unsigned eq0[$];   // expected frame sums per requester
    int unsigned eq1[$];
    int          hs_cnt[2];
    int          n_clr, n_vin, n_both, n_rdy1;

    task automatic drive_one(input int r);
        logic [DW:0] h;
        bit          has;
        has = (r == 0) ? (sq0.size() > 0) : (sq1.size() > 0);
        h   = '0;
        if (has) h = (r == 0) ? sq0[0] : sq1[0];
        req_valid[r] = h[DW];
        req_data[r]  = h[DW] ? h[DW-1:0] : DW'($urandom);
        // req_ready only moves on posedge, so its value here decides the
        // handshake at the coming edge.
        if (has && (!h[DW] || req_ready[r])) begin
            if (r == 0) void'(sq0.pop_front());
            else        void'(sq1.pop_front());
            if (h[DW]) hs_cnt[r]++;
        end
    endtask

    initial begin : sources
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            drive_one(0);
            drive_one(1);
            if (acc_clr)            n_clr++;
            if (acc_valid_in)       n_vin++;
            if (req_ready == 2'b11) n_both++;
            if (req_ready[1])       n_rdy1++;
        end
    end

    // ---------------- helpers ------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_frame(input int r, input int unsigned el[LEN], input int gap[LEN]);
        int unsigned s = 0;
        for (int i = 0; i < LEN; i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                if (r == 0) sq0.push_back({1'b0, DW'(0)});
                else        sq1.push_back({1'b0, DW'(0)});
            end
            if (r == 0) sq0.push_back({1'b1, DW'(el[i])});
            else        sq1.push_back({1'b1, DW'(el[i])});
            s += el[i] * el[i];
        end
        if (r == 0) eq0.push_back(s);
        else        eq1.push_back(s);
    endtask

    task automatic wait_res_valid(input string tag);
        int n = 0;
        while (res_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_res_valid"}, 32'(res_valid), 32'd1);
    endtask

    // Waits for a result, holds res_ready low for 'hold' cycles checking the
    // result stays put, optionally pulses acc_overflow while in RESULT, then
    // accepts it and checks it against the expected requester's next sum.
    task automatic take_and_check(input string tag, input logic exp_id, input int hold,
                                  input bit inj, input bit sat);
        logic            id, o;
        logic [FW-1:0]   d;
        int unsigned     expv;
        wait_res_valid(tag);
        id = res_id;
        d  = res_data;
        o  = res_ovf;
        for (int k = 0; k < hold; k++) begin
            if (inj && k == 1) ovf_inj = 1'b1;
            tick();
            ovf_inj = 1'b0;
            check({tag, "_hold"}, {7'd0, res_valid, res_id, res_ovf, req_ready, res_data},
                  {7'd0, 1'b1, id, o, 2'b00, d});
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_accept"}, 32'(res_valid), 32'd0);
        if (exp_id) expv = (eq1.size() > 0) ? eq1.pop_front() : 32'hFFFF_FFFF;
        else        expv = (eq0.size() > 0) ? eq0.pop_front() : 32'hFFFF_FFFF;
        if (sat) expv = (32'd1 << FW) - 32'd1;
        check({tag, "_id"},   32'(id), 32'(exp_id));
        check({tag, "_data"}, 32'(d),  expv);
        check({tag, "_ovf"},  32'(o),  32'(sat));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------------------
    initial begin : main
        int unsigned el[LEN];
        int          gp[LEN];
        int unsigned t_hs;
        int          n;
        int          base;
        logic        exp_last;

        res_ready = 1'b0;
        ovf_inj   = 1'b0;
        reset     = 1'b1;
        #1 reset  = 1'b0;
        #2;
        check("rst_outs_a", {24'd0, busy, req_ready, acc_clr, acc_valid_in, res_valid, res_id, res_ovf},
              32'd0);
        check("rst_outs_b", {4'd0, acc_a, res_data}, 32'd0);

        // Both requesters valid out of reset: requester 0 wins first.
        el = '{5, 5, 5, 5}; gp = '{0, 0, 0, 0};
        send_frame(0, el, gp);
        el = '{2, 2, 2, 2};
        send_frame(1, el, gp);
        n_rdy1 = 0;
        tick();
        reset = 1'b1;
        wait_res_valid("t2_first");
        check("t2_rdy1_during_req0", 32'(n_rdy1), 32'd0);
        check("t2_req1_untouched", 32'(hs_cnt[1]), 32'd0);
        take_and_check("t2a", 1'b0, 0, 1'b0, 1'b0);
        take_and_check("t2b", 1'b1, 0, 1'b0, 1'b0);

        // Req0 alone 1,2,3,4: latency, clear pulse and issue pulses.
        n_clr = 0; n_vin = 0; base = hs_cnt[0];
        el = '{1, 2, 3, 4}; gp = '{0, 0, 0, 0};
        send_frame(0, el, gp);
        n = 0;
        while (hs_cnt[0] == base && n < 100) begin tick(); n++; end
        t_hs = cyc;
        n = 0;
        while (res_valid !== 1'b1 && n < 100) begin tick(); n++; end
        check("t1_latency", cyc - t_hs, 32'(LEN + ACC_LAT + 1));
        take_and_check("t1", 1'b0, 0, 1'b0, 1'b0);
        check("t1_clr_pulses", 32'(n_clr), 32'd1);
        check("t1_vin_pulses", 32'(n_vin), 32'd4);

        // Req1 with bubbles: 3,_,_,4,1,1.
        n_vin = 0;
        el = '{3, 4, 1, 1}; gp = '{0, 2, 0, 0};
        send_frame(1, el, gp);
        take_and_check("t3", 1'b1, 0, 1'b0, 1'b0);
        check("t3_vin_pulses", 32'(n_vin), 32'd4);

        // Overflow pulse mid-frame saturates the result.
        n_vin = 0;
        el = '{255, 255, 255, 255}; gp = '{0, 0, 0, 0};
        send_frame(0, el, gp);
        n = 0;
        while (n_vin < 2 && n < 100) begin tick(); n++; end
        ovf_inj = 1'b1;
        tick();
        ovf_inj = 1'b0;
        take_and_check("t4", 1'b0, 0, 1'b0, 1'b1);

        // Held result; other requester queued meanwhile gets the next grant.
        el = '{10, 20, 30, 40}; gp = '{0, 0, 0, 0};
        send_frame(0, el, gp);
        wait_res_valid("t5_pre");
        el = '{7, 8, 9, 6};
        send_frame(1, el, gp);
        el = '{1, 0, 2, 0};
        send_frame(0, el, gp);
        take_and_check("t5a", 1'b0, 5, 1'b1, 1'b0);
        take_and_check("t5b", 1'b1, 0, 1'b0, 1'b0);
        take_and_check("t5c", 1'b0, 0, 1'b0, 1'b0);

        // Random frames on both requesters: grants must alternate.
        for (int f = 0; f < 6; f++) begin
            for (int r = 0; r < 2; r++) begin
                for (int i = 0; i < LEN; i++) begin
                    el[i] = $urandom_range(0, 255);
                    gp[i] = (i == 0) ? 0 : int'($urandom_range(0, 2));
                end
                send_frame(r, el, gp);
            end
        end
        exp_last = 1'b0;
        for (int k = 0; k < 12; k++) begin
            take_and_check("rand", ~exp_last, int'($urandom_range(0, 3)), 1'b0, 1'b0);
            exp_last = ~exp_last;
        end
        check("no_double_ready", 32'(n_both), 32'd0);

        // Reset mid-frame after two handshakes.
        el = '{7, 7, 7, 7}; gp = '{0, 0, 0, 0};
        send_frame(0, el, gp);
        base = hs_cnt[0];
        n = 0;
        while (hs_cnt[0] < base + 2 && n < 100) begin tick(); n++; end
        tick();
        #2 reset = 1'b0;
        #1;
        check("t6_rst_outs_a", {24'd0, busy, req_ready, acc_clr, acc_valid_in, res_valid, res_id, res_ovf},
              32'd0);
        check("t6_rst_outs_b", {4'd0, acc_a, res_data}, 32'd0);
        sq0.delete(); sq1.delete(); eq0.delete(); eq1.delete();
        tick();
        tick();
        check("t6_held_idle", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        el = '{1, 1, 1, 1};
        send_frame(0, el, gp);
        el = '{9, 9, 9, 9};
        send_frame(1, el, gp);
        take_and_check("t6a", 1'b0, 0, 1'b0, 1'b0);
        take_and_check("t6b", 1'b1, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
